apb_perim_master: RTL and testbench
===================================

APB_PERIM_MASTER -- requirements
Module: apb_perim_master

Interface
REQ-001 The block SHALL have the parameter ADDR_A, default 32'h0, giving the APB address of side-a register.
REQ-002 The block SHALL have the parameter ADDR_B, default 32'h4, giving the APB address of side-b register.
REQ-003 The block SHALL have the parameter ADDR_R, default 32'h8, giving the APB address of the perimeter result register.
REQ-004 The block SHALL have the parameter TIMEOUT, default 16, giving the maximum ACCESS cycles waiting for PREADY, range 1..255.
REQ-005 The block SHALL have the port PCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have the port PRESET, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have the port start, input, 1 bit: a one-cycle request to compute; honoured only when busy=0.
REQ-008 The block SHALL have the ports a_in and b_in, input, 32 bits each: side lengths, sampled on an accepted start.
REQ-009 The block SHALL have the ports busy, done and error, output, 1 bit each: sequence active, one-cycle success pulse, and one-cycle timeout pulse.
REQ-010 The block SHALL have the port result, output, 32 bits: the perimeter read back, held until the next done.
REQ-011 The block SHALL have the APB requester ports PSEL, PENABLE and PWRITE (output, 1 bit each), PADDR and PWDATA (output, 32 bits each), and PRDATA (input, 32 bits) and PREADY (input, 1 bit).

Function
REQ-012 On an accepted start, the block SHALL latch a_in and b_in and run three APB transfers in order: write a to ADDR_A, write b to ADDR_B, read ADDR_R.
REQ-013 The transfer FSM SHALL use the states IDLE, SETUP and ACCESS.
- IDLE->SETUP on accepted start or next pending transfer.
- SETUP->ACCESS unconditionally after one cycle.
- ACCESS->SETUP or IDLE on PREADY=1.
REQ-014 In SETUP the block SHALL assert PSEL=1, PENABLE=0 and drive PADDR, PWRITE and PWDATA valid.
REQ-015 In ACCESS the block SHALL assert PSEL=1, PENABLE=1 and hold PADDR, PWRITE and PWDATA stable until PREADY is sampled high.
REQ-016 The block SHALL deassert PENABLE on the same edge PREADY=1 is sampled, and SHALL return to SETUP the next cycle with no IDLE gap between transfers.
REQ-017 The block SHALL capture the read transfer's PRDATA into result on the edge PREADY=1 is sampled in ACCESS with PWRITE=0.
REQ-018 The block SHALL pulse done for one cycle, and return to IDLE, on the cycle after the read completes; minimum start-to-done latency is 7 cycles with zero-wait PREADY.
REQ-019 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-020 When the wait counter reaches TIMEOUT, the block SHALL abort the sequence, drop PSEL and PENABLE, pulse error for one cycle, leave result unchanged and return to IDLE.
REQ-021 The block SHALL keep busy=1 from the cycle after an accepted start until the cycle of done or error, inclusive.
REQ-022 The block SHALL ignore start while busy=1; start arriving in the same cycle as done or error SHALL be ignored.
REQ-023 In IDLE, the block SHALL drive PSEL=0 and PENABLE=0, with PADDR, PWDATA and PWRITE holding their last values.
REQ-024 The block SHALL perform no arithmetic; result is the 32-bit value returned, and wrap-around is the responder's concern.

Reset
REQ-025 Asserting PRESET at any time, including mid-transfer, SHALL immediately force:
- the FSM to IDLE and the pending-transfer index to 0;
- PSEL, PENABLE, PWRITE, busy, done, error = 0;
- PADDR, PWDATA, result and the wait counter = 0;
- the latched a and b = 0.
REQ-026 After PRESET deasserts, the block SHALL accept the first start on the next rising edge.

Structure
REQ-027 The package apb_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS), the transfer-index type (XFER_A, XFER_B, XFER_R) and the default address constants.
REQ-028 A sub-module apb_master_xfer SHALL perform one APB transfer, including the timeout; apb_perim_master SHALL sequence three such transfers.

Verification
REQ-029 The bench SHALL check: start with a=3, b=5 against the perimeter responder -> APB writes 3@0x0 and 5@0x4, read @0x8, done after 7+ cycles, result=16, error=0.
REQ-030 The bench SHALL check: a=32'hFFFF_FFFF, b=1 -> result=0, done=1.
REQ-031 The bench SHALL check: a responder holding PREADY=0 on the second write, TIMEOUT=4 -> error pulses once after 4 ACCESS cycles, PSEL=0, result retains its prior value.
REQ-032 The bench SHALL check: a second start with a=7, b=9 during busy -> ignored, only the first sequence appears on APB, result=16.
REQ-033 The bench SHALL check: PRESET asserted during ACCESS of the second write -> PSEL=0, busy=0 and result=0 immediately; a later start with a=1, b=2 gives result=6.
REQ-034 The bench SHALL check: a protocol monitor over all scenarios -> PENABLE is never high without PSEL, PADDR and PWDATA are stable from SETUP until PREADY, and PENABLE is never high two cycles after PREADY.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default register map for the APB perimeter requester.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  typedef enum logic [1:0] {XFER_A, XFER_B, XFER_R} xfer_t;

  localparam logic [31:0] DEF_ADDR_A = 32'h0;
  localparam logic [31:0] DEF_ADDR_B = 32'h4;
  localparam logic [31:0] DEF_ADDR_R = 32'h8;

endpackage

// File: rtl/apb_perim_master_if.sv
// APB requester/completer signal bundle.
interface apb_perim_master_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_master_xfer.sv
// One APB transfer engine with wait timeout; chains straight into the next
// transfer when the sequencer flags one as pending.
//   state  | meaning
//   IDLE   | bus parked, PSEL=0, address/data hold last values
//   SETUP  | PSEL=1, PENABLE=0, address/data/direction driven
//   ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
module apb_master_xfer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        go,
  input  logic        more,
  input  logic        nxt_write,
  input  logic [31:0] nxt_addr,
  input  logic [31:0] nxt_wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  apb_perim_master_if.master bus
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  apb_state_t state;
  logic [7:0] wait_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      bus.PSEL    <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= 32'h0;
      bus.PWDATA  <= 32'h0;
      wait_cnt    <= 8'h0;
      ack         <= 1'b0;
      err         <= 1'b0;
      rdata       <= 32'h0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state      <= SETUP;
            bus.PSEL   <= 1'b1;
            bus.PWRITE <= nxt_write;
            bus.PADDR  <= nxt_addr;
            bus.PWDATA <= nxt_wdata;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
          wait_cnt    <= 8'h0;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.PENABLE <= 1'b0;
            ack         <= 1'b1;
            if (!bus.PWRITE) rdata <= bus.PRDATA;
            // Back-to-back: the next transfer's SETUP follows with no IDLE gap.
            if (more) begin
              state      <= SETUP;
              bus.PWRITE <= nxt_write;
              bus.PADDR  <= nxt_addr;
              bus.PWDATA <= nxt_wdata;
            end else begin
              state    <= IDLE;
              bus.PSEL <= 1'b0;
            end
          end else if (wait_cnt == LIMIT) begin
            state       <= IDLE;
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            err         <= 1'b1;
            wait_cnt    <= wait_cnt + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_perim_master.sv
// Sequences write-a, write-b, read-perimeter over APB and reports the read value.
module apb_perim_master
  import apb_pkg::*;
#(
  parameter logic [31:0] ADDR_A  = DEF_ADDR_A,
  parameter logic [31:0] ADDR_B  = DEF_ADDR_B,
  parameter logic [31:0] ADDR_R  = DEF_ADDR_R,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  apb_perim_master_if.master bus
);

  xfer_t       idx;
  xfer_t       nxt_idx;
  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic        go;
  logic        more;
  logic        nxt_write;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_wdata;
  logic        x_ack;

  assign go   = start && !busy;
  assign more = busy && (idx != XFER_R);

  // The first write launches on the accepting edge, so it takes a_in directly.
  always_comb begin
    nxt_idx = XFER_A;
    if (busy) begin
      case (idx)
        XFER_A:  nxt_idx = XFER_B;
        default: nxt_idx = XFER_R;
      endcase
    end
    nxt_write = 1'b1;
    nxt_addr  = ADDR_A;
    nxt_wdata = busy ? a_lat : a_in;
    case (nxt_idx)
      XFER_B: begin
        nxt_addr  = ADDR_B;
        nxt_wdata = b_lat;
      end
      XFER_R: begin
        nxt_write = 1'b0;
        nxt_addr  = ADDR_R;
        nxt_wdata = b_lat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx   <= XFER_A;
      a_lat <= 32'h0;
      b_lat <= 32'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        a_lat <= a_in;
        b_lat <= b_in;
        busy  <= 1'b1;
        idx   <= XFER_A;
      end else if (done || error) begin
        busy <= 1'b0;
      end else if (x_ack) begin
        if (idx == XFER_R) done <= 1'b1;
        else               idx  <= nxt_idx;
      end
    end
  end

  apb_master_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .go        (go),
    .more      (more),
    .nxt_write (nxt_write),
    .nxt_addr  (nxt_addr),
    .nxt_wdata (nxt_wdata),
    .ack       (x_ack),
    .err       (error),
    .rdata     (result),
    .bus       (bus)
  );

endmodule

// File: tb/tb_apb_perim_master.sv
// Bench: perimeter responder, transfer/result scoreboard and APB protocol monitor.
module tb_apb_perim_master;
  import apb_pkg::*;

  localparam int TMO = 4;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_s;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          waits;
    logic [31:0] exp;
  } vec_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = 32'h0;
  logic [31:0] b_in = 32'h0;
  logic        busy, done, error;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  xfer_s       exp_x[$];
  logic [31:0] exp_res[$];

  int          wait_n = 0;
  logic        stall_b = 1'b0;
  logic [31:0] reg_a = 32'h0;
  logic [31:0] reg_b = 32'h0;
  logic [7:0]  acc_cnt = 8'h0;

  apb_perim_master_if bus ();

  apb_perim_master #(.TIMEOUT(TMO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  // Perimeter responder: registers at 0x0/0x4, reads return 2*(a+b) modulo 2^32.
  always_comb begin
    bus.PREADY = bus.PSEL && bus.PENABLE && (int'(acc_cnt) >= wait_n)
                 && !(stall_b && bus.PWRITE && (bus.PADDR == 32'h4));
    bus.PRDATA = (reg_a + reg_b) << 1;
  end

  always @(posedge PCLK)
    acc_cnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acc_cnt + 8'd1 : 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_x(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    xfer_s t;
    t.wr   = wr;
    t.addr = addr;
    t.data = data;
    exp_x.push_back(t);
  endtask

  // Monitor and scoreboard, sampled mid-cycle on the falling edge.
  initial begin
    logic        p_sel, p_en, p_rdy, p_wr;
    logic [31:0] p_addr, p_wdata;
    xfer_s       t;
    p_sel = 0; p_en = 0; p_rdy = 0; p_wr = 0; p_addr = 0; p_wdata = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        p_sel = 0; p_en = 0; p_rdy = 0;
      end else begin
        if (bus.PENABLE) chk("penable_needs_psel", 32'(bus.PSEL), 32'd1);
        if (p_sel && !(p_en && p_rdy) && bus.PSEL && bus.PENABLE) begin
          chk("paddr_stable", bus.PADDR, p_addr);
          chk("pwdata_stable", bus.PWDATA, p_wdata);
          chk("pwrite_stable", 32'(bus.PWRITE), 32'(p_wr));
        end
        if (p_en && p_rdy) chk("penable_drops_after_ready", 32'(bus.PENABLE), 32'd0);
        if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
          if (exp_x.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_xfer: got addr %0h data %0h, expected none", bus.PADDR, bus.PWDATA);
          end else begin
            t = exp_x.pop_front();
            chk("xfer_dir", 32'(bus.PWRITE), 32'(t.wr));
            chk("xfer_addr", bus.PADDR, t.addr);
            chk("xfer_data", bus.PWRITE ? bus.PWDATA : bus.PRDATA, t.data);
          end
          if (bus.PWRITE && bus.PADDR == 32'h0) reg_a = bus.PWDATA;
          if (bus.PWRITE && bus.PADDR == 32'h4) reg_b = bus.PWDATA;
        end
        if (done) begin
          if (exp_res.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got result %0h, expected no done", result);
          end else begin
            chk("result", result, exp_res.pop_front());
          end
        end
        p_sel = bus.PSEL; p_en = bus.PENABLE; p_rdy = bus.PREADY;
        p_wr = bus.PWRITE; p_addr = bus.PADDR; p_wdata = bus.PWDATA;
      end
    end
  end

  // Caller is positioned just after a falling edge.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input int w,
                         input logic [31:0] exp);
    int cyc;
    wait_n = w;
    push_x(1'b1, 32'h0, a);
    push_x(1'b1, 32'h4, b);
    push_x(1'b0, 32'h8, exp);
    exp_res.push_back(exp);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    a_in = $urandom; b_in = $urandom;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc - 1), 32'(7 + 3 * w));
    chk("no_error_on_done", 32'(error), 32'd0);
    chk("busy_during_done", 32'(busy), 32'd1);
    @(negedge PCLK);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   cyc;
    int   acc;
    vecs[0] = '{a: 32'd3,          b: 32'd5,   waits: 0, exp: 32'd16};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,   waits: 0, exp: 32'd0};
    vecs[2] = '{a: 32'd10,         b: 32'd20,  waits: 1, exp: 32'd60};
    vecs[3] = '{a: 32'd100,        b: 32'd250, waits: 3, exp: 32'd700};
    vecs[4] = '{a: 32'h8000_0000,  b: 32'd0,   waits: 2, exp: 32'd0};
    vecs[5] = '{a: 32'h1234,       b: 32'd1,   waits: 0, exp: 32'h246A};

    repeat (3) @(negedge PCLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_paddr", bus.PADDR, 32'd0);
    chk("rst_pwdata", bus.PWDATA, 32'd0);
    PRESET = 1'b0;

    for (int i = 0; i < 6; i++) run_one(vecs[i].a, vecs[i].b, vecs[i].waits, vecs[i].exp);

    // Stalled second write: timeout after TMO access cycles, result untouched.
    stall_b = 1'b1; wait_n = 0;
    push_x(1'b1, 32'h0, 32'h11);
    a_in = 32'h11; b_in = 32'h22; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    cyc = 1; acc = 0;
    while (!error && cyc < 100) begin
      if (bus.PSEL && bus.PENABLE && bus.PADDR == 32'h4) acc++;
      @(negedge PCLK);
      cyc++;
    end
    chk("timeout_error_seen", 32'(error), 32'd1);
    chk("timeout_access_cycles", 32'(acc), 32'(TMO));
    chk("timeout_latency", 32'(cyc), 32'd8);
    chk("timeout_psel", 32'(bus.PSEL), 32'd0);
    chk("timeout_penable", 32'(bus.PENABLE), 32'd0);
    chk("timeout_no_done", 32'(done), 32'd0);
    chk("timeout_result_kept", result, vecs[5].exp);
    @(negedge PCLK);
    chk("error_one_cycle", 32'(error), 32'd0);
    chk("busy_clear_after_error", 32'(busy), 32'd0);
    stall_b = 1'b0;

    // Second start while busy and a start coinciding with done are both dropped.
    push_x(1'b1, 32'h0, 32'd3);
    push_x(1'b1, 32'h4, 32'd5);
    push_x(1'b0, 32'h8, 32'd16);
    exp_res.push_back(32'd16);
    a_in = 32'd3; b_in = 32'd5; start = 1'b1;
    @(negedge PCLK);
    a_in = 32'd7; b_in = 32'd9;
    repeat (2) @(negedge PCLK);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
    end
    chk("ignore_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    chk("start_on_done_ignored", 32'(busy), 32'd0);
    repeat (3) @(negedge PCLK);
    chk("ignore_no_extra_xfer", 32'(bus.PSEL), 32'd0);
    chk("ignore_result", result, 32'd16);

    // Reset while the second write sits in ACCESS.
    stall_b = 1'b1;
    push_x(1'b1, 32'h0, 32'h55);
    a_in = 32'h55; b_in = 32'h66; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    cyc = 0;
    while (!(bus.PSEL && bus.PENABLE && bus.PADDR == 32'h4) && cyc < 50) begin
      @(negedge PCLK);
      cyc++;
    end
    chk("reached_access_b", 32'(bus.PENABLE), 32'd1);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_psel", 32'(bus.PSEL), 32'd0);
    chk("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_paddr", bus.PADDR, 32'd0);
    @(negedge PCLK);
    stall_b = 1'b0;
    PRESET = 1'b0;
    run_one(32'd1, 32'd2, 0, 32'd6);

    chk("xfer_queue_drained", 32'(exp_x.size()), 32'd0);
    chk("result_queue_drained", 32'(exp_res.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
